// File: rtl/ofifo_pkg.sv
// Shared constants for the OS-mode array FIFOs plus the lane slicing helper.
// Used by os_ofifo and os_ofifo_col (and the input FIFO on the other side).
package ofifo_pkg;

    localparam int OS_BW    = 16;
    localparam int OS_COL   = 8;
    localparam int OS_DEPTH = 64;

    // Low bit of lane `lane` in a bus of `w`-bit lanes; the lane is [lo +: w].
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/os_ofifo_col.sv
// Single-lane circular buffer: one per array column in os_ofifo.
// Ports: clk, reset (async high), wr/din write side, pop/dout registered read,
//        full/empty status from the occupancy count.
module os_ofifo_col
    import ofifo_pkg::*;
#(
    parameter int bw    = OS_BW,
    parameter int depth = OS_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [bw-1:0] din,
    input  logic          pop,
    output logic [bw-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int ADDR_W = $clog2(depth);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(depth);

    logic [bw-1:0]     mem [depth];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              wr_ok;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    // Full is judged on the count before this cycle's pop.
    assign wr_ok = wr & ~full;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/os_ofifo.sv
// OS-mode output FIFO: per-column buffers, pops one aligned row when all lanes hold data.
// Ports: clk, reset (async high), wr[col]/in write lanes, rd pop request,
//        out registered row, o_full/o_ready status, o_valid pop pulse.
// Optional: OS_OFIFO_ERR_EN adds sticky o_err (dropped write or rd with no row).
module os_ofifo
    import ofifo_pkg::*;
#(
    parameter int bw    = OS_BW,
    parameter int col   = OS_COL,
    parameter int depth = OS_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col-1:0]    wr,
    input  logic [bw*col-1:0] in,
    input  logic              rd,
    output logic [bw*col-1:0] out,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_valid
`ifdef OS_OFIFO_ERR_EN
    ,
    output logic              o_err
`endif
);

    logic [col-1:0] full;
    logic [col-1:0] empty;
    logic           row_avail;
    logic           pop;

    assign row_avail = ~|empty;
    assign pop       = rd & row_avail;
    assign o_full    = |full;
    assign o_ready   = ~o_full;

    for (genvar c = 0; c < col; c++) begin : g_col
        os_ofifo_col #(
            .bw    (bw),
            .depth (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .din   (in[lane_lo(c, bw) +: bw]),
            .pop   (pop),
            .dout  (out[lane_lo(c, bw) +: bw]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_valid <= 1'b0;
        else
            o_valid <= pop;
    end

`ifdef OS_OFIFO_ERR_EN
    logic bad;

    assign bad = (|(wr & full)) | (rd & ~row_avail);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_err <= 1'b0;
        else if (bad)
            o_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_os_ofifo.sv
// Self-checking bench for os_ofifo: directed scenarios plus randomized traffic,
// compared each cycle against a per-lane queue model of the FIFO.
module tb_os_ofifo;

    localparam int BW = 16;
    localparam int COL = 8;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [COL-1:0]      wr;
    logic [BW*COL-1:0]   in;
    logic                rd;
    logic [BW*COL-1:0]   out;
    logic                o_full;
    logic                o_ready;
    logic                o_valid;
`ifdef OS_OFIFO_ERR_EN
    logic                o_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [BW-1:0]     q [COL][$];
    logic [BW*COL-1:0] exp_out;
    logic              exp_valid;
    logic              exp_err;
    int                nvalid;

    os_ofifo #(.bw(BW), .col(COL), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .in      (in),
        .rd      (rd),
        .out     (out),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_valid (o_valid)
`ifdef OS_OFIFO_ERR_EN
        ,
        .o_err   (o_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < COL; c++)
            q[c].delete();
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    // One clock: drive at negedge, check status, advance model, check after edge.
    task automatic cycle(input logic [COL-1:0] w, input logic [BW*COL-1:0] d,
                         input logic r);
        logic avail;
        logic anyfull;
        logic drop;
        logic [COL-1:0] push;
        wr = w;
        in = d;
        rd = r;
        avail = 1'b1;
        anyfull = 1'b0;
        drop = 1'b0;
        for (int c = 0; c < COL; c++) begin
            if (q[c].size() == DEPTH) anyfull = 1'b1;
            if (q[c].size() == 0) avail = 1'b0;
            push[c] = w[c] && (q[c].size() < DEPTH);
            if (w[c] && !push[c]) drop = 1'b1;
        end
        #1;
        check("o_full", o_full, anyfull);
        check("o_ready", o_ready, !anyfull);
        if ((r && !avail) || drop) exp_err = 1'b1;
        if (r && avail) begin
            for (int c = 0; c < COL; c++)
                exp_out[BW*c +: BW] = q[c].pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        for (int c = 0; c < COL; c++)
            if (push[c]) q[c].push_back(d[BW*c +: BW]);
        @(posedge clk);
        @(negedge clk);
        if (o_valid) nvalid++;
        check("o_valid", o_valid, exp_valid);
        check("out", out, exp_out);
`ifdef OS_OFIFO_ERR_EN
        check("o_err", o_err, exp_err);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_out", out, '0);
        check("rst_full", o_full, 1'b0);
        check("rst_ready", o_ready, 1'b1);
`ifdef OS_OFIFO_ERR_EN
        check("rst_err", o_err, 1'b0);
`endif
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [BW*COL-1:0] row(input int k);
        logic [BW*COL-1:0] r;
        for (int c = 0; c < COL; c++)
            r[BW*c +: BW] = BW'(16 * k + c);
        return r;
    endfunction

    initial begin
        logic [BW*COL-1:0] d;
        logic [COL-1:0] w;
        int pw;
        int pr;
        reset = 1'b1;
        wr = '0;
        in = '0;
        rd = 1'b0;
        nvalid = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // mid-stream reset with 5 rows stored
        for (int k = 0; k < 5; k++)
            cycle('1, row(k + 40), 1'b0);
        do_reset();
        cycle('0, '0, 1'b1);
        do_reset();

        // skewed fill: lane c written at cycle c, rd every cycle
        nvalid = 0;
        for (int c = 0; c < COL + 3; c++) begin
            d = '0;
            w = '0;
            if (c < COL) begin
                w[c] = 1'b1;
                d[BW*c +: BW] = BW'(16'h0100 + c);
            end
            cycle(w, d, 1'b1);
        end
        check("skew_pulses", 128'(nvalid), 128'd1);
        check("skew_row", out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                                16'h0103, 16'h0102, 16'h0101, 16'h0100});
        do_reset();

        // fill lane 3 to full, one extra dropped write, then fill others and drain
        for (int k = 0; k < DEPTH + 1; k++) begin
            d = '0;
            d[BW*3 +: BW] = (k == DEPTH) ? 16'hdead : BW'(k);
            cycle(8'h08, d, 1'b0);
        end
        check("full_lane3", o_full, 1'b1);
        for (int k = 0; k < DEPTH; k++)
            cycle(8'hf7, row(k), 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) begin
            cycle('0, '0, 1'b1);
            if (k < DEPTH)
                check("full_l3_data", 128'(out[BW*3 +: BW]), 128'(k));
        end
        do_reset();

        // wrap: 200 rows with overlapping rd/wr
        nvalid = 0;
        for (int k = 0; k < 201; k++)
            cycle((k < 200) ? '1 : '0, row(k), k > 0);
        check("wrap_pulses", 128'(nvalid), 128'd200);
        do_reset();

        // simultaneous write and read with one row stored
        cycle('1, row(7), 1'b0);
        cycle('1, row(8), 1'b1);
        check("simul_old", out, row(7));
        cycle('0, '0, 1'b1);
        check("simul_new", out, row(8));
        cycle('0, '0, 1'b1);
        do_reset();

        // randomized traffic with phases biased toward full and toward empty
        for (int ph = 0; ph < 16; ph++) begin
            pw = (ph % 4 == 0) ? 95 : $urandom_range(10, 90);
            pr = (ph % 4 == 0) ? 5 : $urandom_range(10, 95);
            for (int i = 0; i < 120; i++) begin
                for (int c = 0; c < COL; c++) begin
                    w[c] = ($urandom_range(0, 99) < pw);
                    d[BW*c +: BW] = BW'($urandom);
                end
                cycle(w, d, $urandom_range(0, 99) < pr);
            end
            if (ph == 9) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
